// File: rtl/gate_unit_seq.sv
// Registered WIDTH-bit bitwise gate unit with eight modes, an internal accumulator operand,
// a single-entry valid/ready output register, and a running transaction counter.
module gate_unit_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    input  logic [2:0]       mode,
    input  logic             acc_en,
    input  logic             acc_clr,
    output logic [WIDTH-1:0] op,
    output logic             op_valid,
    input  logic             op_ready,
    output logic             op_any,
    output logic             op_all,
    output logic [CNT_W-1:0] txn_cnt
);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   op_q, op_d;
    logic               any_q, any_d;
    logic               all_q, all_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               accept;
    logic               consume;
    logic [WIDTH-1:0]   acc_eff;
    logic [WIDTH-1:0]   opnd_b;
    logic [WIDTH-1:0]   result;

    assign op_valid = (state_q == S_FULL);
    assign in_ready = !op_valid || op_ready;
    assign accept   = in_valid && in_ready;
    assign consume  = op_valid && op_ready;

    assign op       = op_q;
    assign op_any   = any_q;
    assign op_all   = all_q;
    assign txn_cnt  = cnt_q;

    // A same-cycle clear feeds zero into the gate rather than the stale accumulator.
    assign acc_eff  = acc_clr ? '0 : acc_q;
    assign opnd_b   = acc_en ? acc_eff : input2;

    always_comb begin
        result = '0;
        unique case (mode)
            3'b000:  result = input1 & opnd_b;
            3'b001:  result = input1 | opnd_b;
            3'b010:  result = input1 ^ opnd_b;
            3'b011:  result = ~(input1 & opnd_b);
            3'b100:  result = ~(input1 | opnd_b);
            3'b101:  result = ~(input1 ^ opnd_b);
            3'b110:  result = ~input1;
            3'b111:  result = input1;
            default: result = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        any_d   = any_q;
        all_d   = all_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        if (accept) begin
            state_d = S_FULL;
            op_d    = result;
            any_d   = |result;
            all_d   = &result;
            acc_d   = result;
            cnt_d   = cnt_q + CNT_W'(1);
        end else begin
            if (consume) begin
                state_d = S_EMPTY;
            end
            if (acc_clr) begin
                acc_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_EMPTY;
            op_q    <= '0;
            any_q   <= 1'b0;
            all_q   <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            any_q   <= any_d;
            all_q   <= all_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
